// File: rtl/tdma_burst_scheduler.sv
// TDMA burst scheduler: walks 8 timeslots per frame and requests one burst in each slot enabled by slot_mask.
// fire_burst is registered and appears one clock after the slot start; missed/overrun status stays until clear_status.
module tdma_burst_scheduler #(
    parameter int unsigned SLOT_CLOCKS = 1250
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  slot_mask,
    input  logic        armed,
    input  logic        txchain_en,
    input  logic        clear_status,
    output logic        fire_burst,
    output logic [2:0]  slot_index,
    output logic [15:0] frame_number,
    output logic        burst_active,
    output logic [7:0]  missed_count,
    output logic        overrun
);
    localparam int unsigned SLOTS_PER_FRAME = 8;
    localparam logic [15:0] LAST_TICK = 16'(SLOT_CLOCKS - 1);
    localparam logic [2:0]  LAST_SLOT = 3'(SLOTS_PER_FRAME - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  slot_q, slot_d;
    logic [15:0] frame_q, frame_d;
    logic        fire_q, fire_d;
    logic        burst_q, burst_d;
    logic        seen_q, seen_d;
    logic [7:0]  missed_q, missed_d;
    logic        overrun_q, overrun_d;

    logic        seen_now;
    logic        miss_inc;
    logic        ovr_set;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        slot_d    = slot_q;
        frame_d   = frame_q;
        fire_d    = 1'b0;
        burst_d   = burst_q;
        seen_d    = seen_q;
        miss_inc  = 1'b0;
        ovr_set   = 1'b0;
        // txchain_en in the slot-start cycle itself counts as activity of the running burst
        seen_now  = seen_q | (burst_q & txchain_en);

        case (state_q)
            IDLE: begin
                timer_d = '0;
                slot_d  = '0;
                frame_d = '0;
                burst_d = 1'b0;
                seen_d  = 1'b0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    timer_d = '0;
                    slot_d  = '0;
                    frame_d = '0;
                    burst_d = 1'b0;
                    seen_d  = 1'b0;
                end else begin
                    if (burst_q) begin
                        if (txchain_en) begin
                            seen_d = 1'b1;
                        end else if (seen_q) begin
                            burst_d = 1'b0;
                            seen_d  = 1'b0;
                        end
                    end

                    if (timer_q == LAST_TICK) begin
                        timer_d = '0;
                        slot_d  = slot_q + 3'd1;
                        if (slot_q == LAST_SLOT) begin
                            frame_d = frame_q + 16'd1;
                        end
                    end else begin
                        timer_d = timer_q + 16'd1;
                    end

                    // slot start decisions override the burst tracking above
                    if (timer_q == 16'd0 && slot_mask[slot_q]) begin
                        if (burst_q && seen_now) begin
                            ovr_set = 1'b1;
                        end else if (burst_q) begin
                            burst_d  = 1'b0;
                            seen_d   = 1'b0;
                            miss_inc = 1'b1;
                        end else if (!armed) begin
                            miss_inc = 1'b1;
                        end else begin
                            fire_d  = 1'b1;
                            burst_d = 1'b1;
                            seen_d  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        missed_d  = missed_q;
        overrun_d = overrun_q;
        if (clear_status) begin
            missed_d  = '0;
            overrun_d = 1'b0;
        end else begin
            if (miss_inc && missed_q != 8'hFF) begin
                missed_d = missed_q + 8'd1;
            end
            if (ovr_set) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            slot_q    <= '0;
            frame_q   <= '0;
            fire_q    <= 1'b0;
            burst_q   <= 1'b0;
            seen_q    <= 1'b0;
            missed_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            slot_q    <= slot_d;
            frame_q   <= frame_d;
            fire_q    <= fire_d;
            burst_q   <= burst_d;
            seen_q    <= seen_d;
            missed_q  <= missed_d;
            overrun_q <= overrun_d;
        end
    end

    assign fire_burst   = fire_q;
    assign slot_index   = slot_q;
    assign frame_number = frame_q;
    assign burst_active = burst_q;
    assign missed_count = missed_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_tdma_burst_scheduler.sv
// Bench for tdma_burst_scheduler at SLOT_CLOCKS=10: directed scenarios plus randomized traffic against a slot-arithmetic model.
module tb_tdma_burst_scheduler;
    localparam int SC = 10;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  slot_mask = 8'h00;
    logic        armed = 1'b0;
    logic        txchain_en = 1'b0;
    logic        clear_status = 1'b0;
    logic        fire_burst;
    logic [2:0]  slot_index;
    logic [15:0] frame_number;
    logic        burst_active;
    logic [7:0]  missed_count;
    logic        overrun;

    int checks = 0;
    int failures = 0;

    logic auto_tx = 1'b0;
    int   tx_len = 3;
    int   tx_cnt = 0;
    int   fb_off = 0;

    always #5 clock = ~clock;

    tdma_burst_scheduler #(.SLOT_CLOCKS(SC)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .slot_mask    (slot_mask),
        .armed        (armed),
        .txchain_en   (txchain_en),
        .clear_status (clear_status),
        .fire_burst   (fire_burst),
        .slot_index   (slot_index),
        .frame_number (frame_number),
        .burst_active (burst_active),
        .missed_count (missed_count),
        .overrun      (overrun)
    );

    // Reference model: position in the schedule is just the clock count since RUN entry.
    logic m_run = 1'b0;
    int   m_t = 0;
    logic m_fire = 1'b0;
    logic m_burst = 1'b0;
    logic m_seen = 1'b0;
    logic m_ovr = 1'b0;
    int   m_missed = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 1'b0; m_t = 0; m_fire = 1'b0; m_burst = 1'b0;
            m_seen = 1'b0; m_ovr = 1'b0; m_missed = 0;
        end else begin : model_step
            logic inc, set, b0, s0;
            inc = 1'b0; set = 1'b0; m_fire = 1'b0;
            if (!m_run) begin
                if (enable) begin m_run = 1'b1; m_t = 0; end
            end else if (!enable) begin
                m_run = 1'b0; m_t = 0; m_burst = 1'b0; m_seen = 1'b0;
            end else begin
                b0 = m_burst;
                s0 = m_seen || (m_burst && txchain_en);
                if (m_burst && txchain_en) m_seen = 1'b1;
                else if (m_burst && m_seen) begin m_burst = 1'b0; m_seen = 1'b0; end
                if ((m_t % SC) == 0 && slot_mask[3'((m_t / SC) % 8)]) begin
                    if (b0 && s0) set = 1'b1;
                    else if (b0) begin m_burst = 1'b0; m_seen = 1'b0; inc = 1'b1; end
                    else if (!armed) inc = 1'b1;
                    else begin m_fire = 1'b1; m_burst = 1'b1; m_seen = 1'b0; end
                end
                m_t = m_t + 1;
            end
            if (clear_status) begin
                m_missed = 0; m_ovr = 1'b0;
            end else begin
                if (inc && m_missed < 255) m_missed = m_missed + 1;
                if (set) m_ovr = 1'b1;
            end
        end
    end

    logic [29:0] act_v;
    assign act_v = {fire_burst, slot_index, frame_number, burst_active, missed_count, overrun};

    function automatic logic [29:0] model_vec();
        logic [2:0]  s;
        logic [15:0] f;
        s = m_run ? 3'((m_t / SC) % 8) : 3'd0;
        f = m_run ? 16'(fb_off + m_t / (8 * SC)) : 16'd0;
        return {m_fire, s, f, m_burst, 8'(m_missed), m_ovr};
    endfunction

    // Advance to the next falling edge and play the burst controller if requested.
    task automatic cyc();
        @(negedge clock);
        clear_status = 1'b0;
        if (auto_tx) begin
            if (m_fire) tx_cnt = tx_len;
            if (tx_cnt > 0) begin txchain_en = 1'b1; tx_cnt = tx_cnt - 1; end
            else txchain_en = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b0; slot_mask = 8'h00; armed = 1'b0;
        txchain_en = 1'b0; clear_status = 1'b0; auto_tx = 1'b0; tx_cnt = 0; fb_off = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (act_v !== 30'd0) begin failures++; $display("FAIL reset_outputs got=%h want=0", act_v); end
        for (int i = 0; i < 5; i++) begin
            cyc();
            checks++;
            if (fire_burst !== 1'b0 || slot_index !== 3'd0 || frame_number !== 16'd0) begin
                failures++; $display("FAIL idle_hold i=%0d got=%h want=0", i, act_v);
            end
            checks++;
            if (missed_count !== 8'd0 || overrun !== 1'b0 || burst_active !== 1'b0) begin
                failures++; $display("FAIL idle_status i=%0d got=%h want=0", i, act_v);
            end
        end
    endtask

    task automatic test_basic();
        do_reset();
        slot_mask = 8'h01; armed = 1'b1; auto_tx = 1'b1; tx_len = 3; enable = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cyc();
            checks++;
            if (act_v !== model_vec()) begin failures++; $display("FAIL basic_model i=%0d got=%h want=%h", i, act_v, model_vec()); end
            checks++;
            if (fire_burst !== ((i % 80) == 1)) begin failures++; $display("FAIL basic_fire i=%0d got=%b want=%b", i, fire_burst, (i % 80) == 1); end
            checks++;
            if (frame_number !== 16'(i / 80) || slot_index !== 3'((i / 10) % 8)) begin
                failures++; $display("FAIL basic_slot_frame i=%0d got=%0d/%0d want=%0d/%0d", i, frame_number, slot_index, i / 80, (i / 10) % 8);
            end
        end
    endtask

    task automatic test_missed_sat();
        int exp;
        do_reset();
        slot_mask = 8'hFF; armed = 1'b0; auto_tx = 1'b1; enable = 1'b1;
        for (int i = 0; i < 3005; i++) begin
            cyc();
            exp = (i + 9) / 10;
            if (exp > 255) exp = 255;
            checks++;
            if (missed_count !== 8'(exp) || fire_burst !== 1'b0) begin
                failures++; $display("FAIL missed_sat i=%0d got=%0d fire=%b want=%0d fire=0", i, missed_count, fire_burst, exp);
            end
            checks++;
            if (act_v !== model_vec()) begin failures++; $display("FAIL missed_model i=%0d got=%h want=%h", i, act_v, model_vec()); end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        slot_mask = 8'h03; armed = 1'b1; enable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            checks++;
            if (fire_burst !== (i == 1)) begin failures++; $display("FAIL ovr_fire i=%0d got=%b want=%b", i, fire_burst, i == 1); end
            checks++;
            if (overrun !== (i >= 11 && i <= 20)) begin failures++; $display("FAIL ovr_flag i=%0d got=%b want=%b", i, overrun, i >= 11 && i <= 20); end
            checks++;
            if (burst_active !== (i >= 1 && i <= 16)) begin failures++; $display("FAIL ovr_burst i=%0d got=%b want=%b", i, burst_active, i >= 1 && i <= 16); end
            checks++;
            if (act_v !== model_vec()) begin failures++; $display("FAIL ovr_model i=%0d got=%h want=%h", i, act_v, model_vec()); end
            txchain_en = (i >= 1 && i <= 15);
            clear_status = (i == 20);
        end
    endtask

    task automatic test_no_tx();
        do_reset();
        slot_mask = 8'h03; armed = 1'b1; enable = 1'b1;
        for (int i = 0; i < 30; i++) begin
            cyc();
            checks++;
            if (fire_burst !== (i == 1)) begin failures++; $display("FAIL notx_fire i=%0d got=%b want=%b", i, fire_burst, i == 1); end
            checks++;
            if (burst_active !== (i >= 1 && i <= 10)) begin failures++; $display("FAIL notx_burst i=%0d got=%b want=%b", i, burst_active, i >= 1 && i <= 10); end
            checks++;
            if (missed_count !== 8'(i >= 11 ? 1 : 0)) begin failures++; $display("FAIL notx_missed i=%0d got=%0d want=%0d", i, missed_count, i >= 11 ? 1 : 0); end
        end
    endtask

    task automatic test_enable_reset();
        do_reset();
        slot_mask = 8'h01; armed = 1'b1; enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if (act_v !== model_vec()) begin failures++; $display("FAIL endrop_model i=%0d got=%h want=%h", i, act_v, model_vec()); end
            if (i >= 4) begin
                checks++;
                if (act_v[29:9] !== 21'd0) begin failures++; $display("FAIL endrop_clear i=%0d got=%h want=0", i, act_v[29:9]); end
            end
            txchain_en = (i >= 1);
            enable = (i < 3);
        end
        txchain_en = 1'b0; enable = 1'b1;
        for (int j = 0; j < 21; j++) begin
            cyc();
            checks++;
            if (fire_burst !== (j == 1) || frame_number !== 16'd0 || slot_index !== 3'(j / 10)) begin
                failures++; $display("FAIL reenable j=%0d got=%h want fire=%b slot=%0d frame=0", j, act_v, j == 1, j / 10);
            end
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (act_v !== 30'd0) begin failures++; $display("FAIL async_reset got=%h want=0", act_v); end
        @(negedge clock);
        enable = 1'b0; reset_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cyc();
            checks++;
            if (act_v !== 30'd0) begin failures++; $display("FAIL post_reset j=%0d got=%h want=0", j, act_v); end
        end
        enable = 1'b1;
        for (int j = 0; j < 12; j++) begin
            cyc();
            checks++;
            if (fire_burst !== (j == 1) || frame_number !== 16'd0) begin
                failures++; $display("FAIL restart j=%0d got=%h want fire=%b frame=0", j, act_v, j == 1);
            end
            checks++;
            if (act_v !== model_vec()) begin failures++; $display("FAIL restart_model j=%0d got=%h want=%h", j, act_v, model_vec()); end
        end
    endtask

    task automatic test_frame_wrap();
        logic [15:0] exp_f;
        do_reset();
        slot_mask = 8'h01; armed = 1'b1; auto_tx = 1'b1; tx_len = 3; enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (i == 6) release dut.frame_q;
            if (i >= 6) begin
                exp_f = (i < 80) ? 16'hFFFF : 16'(i / 80 - 1);
                checks++;
                if (frame_number !== exp_f) begin failures++; $display("FAIL frame_wrap i=%0d got=%h want=%h", i, frame_number, exp_f); end
                checks++;
                if (fire_burst !== ((i % 80) == 1)) begin failures++; $display("FAIL wrap_fire i=%0d got=%b want=%b", i, fire_burst, (i % 80) == 1); end
                checks++;
                if (act_v !== model_vec()) begin failures++; $display("FAIL wrap_model i=%0d got=%h want=%h", i, act_v, model_vec()); end
            end
            if (i == 5) begin
                force dut.frame_q = 16'hFFFF;
                fb_off = 65535;
            end
        end
        fb_off = 0;
    endtask

    task automatic test_random();
        do_reset();
        auto_tx = 1'b1; enable = 1'b1; armed = 1'b1; slot_mask = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            cyc();
            checks++;
            if (act_v !== model_vec()) begin failures++; $display("FAIL random_model i=%0d got=%h want=%h", i, act_v, model_vec()); end
            if ($urandom_range(0, 40) == 0) slot_mask = 8'($urandom);
            armed = ($urandom_range(0, 3) != 0);
            tx_len = $urandom_range(1, 13);
            clear_status = ($urandom_range(0, 150) == 0);
            enable = ($urandom_range(0, 250) != 0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_missed_sat();
        test_overrun();
        test_no_tx();
        test_enable_reset();
        test_frame_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
